spi_sclk_ctrl: RTL

//  Parametrised SPI serial-clock engine. It generates SCLK in all four CPOL/CPHA modes with programmable half-periods
//  and emits a burst of exactly N SCLK cycles per request. Sample/shift strobes are aligned to SCLK edges.

---
 rtl/spi_sclk_pkg.sv | 37 +++
 rtl/spi_sclk_halfcnt.sv | 43 ++++
 rtl/spi_sclk_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_sclk_pkg.sv
// Shared types for the SPI serial-clock engine: FSM states, the
// configuration record and the SPI mode encodings.
package spi_sclk_pkg;

  // Widest divider the configuration record can hold; the engine uses
  // the low DivWidth bits of each divider field.
  localparam int unsigned CfgDivMaxW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LEAD = 2'b01,
    ACT  = 2'b10
  } state_e;

  typedef struct packed {
    logic [CfgDivMaxW-1:0] div_hi;
    logic [CfgDivMaxW-1:0] div_lo;
    logic                  cpol;
    logic                  cpha;
  } sclk_cfg_t;

  localparam logic [1:0] SpiMode0 = 2'b00;
  localparam logic [1:0] SpiMode1 = 2'b01;
  localparam logic [1:0] SpiMode2 = 2'b10;
  localparam logic [1:0] SpiMode3 = 2'b11;

  // Classic SPI mode number {CPOL, CPHA}.
  function automatic logic [1:0] spi_mode(input sclk_cfg_t cfg);
    return {cfg.cpol, cfg.cpha};
  endfunction

  // The leading SCLK edge is the sample edge only in CPHA=0 modes.
  function automatic logic sample_on_lead(input sclk_cfg_t cfg);
    return (spi_mode(cfg) == SpiMode0) || (spi_mode(cfg) == SpiMode2);
  endfunction

endpackage

// File: rtl/spi_sclk_halfcnt.sv
// Loadable half-period down-counter. A load value of 0 is treated as 1,
// so a half-period always lasts at least one soc_clk cycle. expire is
// high during the last cycle of the half-period.
module spi_sclk_halfcnt #(
  parameter int unsigned DivWidth = 8
) (
  input  logic                soc_clk_i,
  input  logic                rst_ni,
  input  logic                load,
  input  logic [DivWidth-1:0] load_val,
  output logic                expire
);

  localparam logic [DivWidth-1:0] One = DivWidth'(1'b1);

  logic [DivWidth-1:0] cnt_r;
  logic [DivWidth-1:0] load_eff_s;

  // Clamp a zero divider to the one-cycle minimum.
  always_comb begin
    if (load_val == {DivWidth{1'b0}}) begin
      load_eff_s = One;
    end else begin
      load_eff_s = load_val;
    end
  end

  // Count down to one and hold there until the next load.
  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= One;
    end else if (load) begin
      cnt_r <= load_eff_s;
    end else if (cnt_r != One) begin
      cnt_r <= cnt_r - One;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == One);

endmodule

// File: rtl/spi_sclk_ctrl.sv
// SPI serial-clock engine: generates SCLK in all four CPOL/CPHA modes
// with programmable idle/active half-periods and emits bursts of exactly
// N SCLK cycles, with sample/shift strobes aligned to the SCLK edges.
// Optional feature macro: SPI_SCLK_CTRL_ABORT_EN adds abort_i, which
// terminates a running burst without strobes or done.
module spi_sclk_ctrl
  import spi_sclk_pkg::*;
#(
  parameter int unsigned          DivWidth     = 8,
  parameter int unsigned          CntWidth     = 8,
  parameter logic [DivWidth-1:0]  InitialDivHi = 8'd1,
  parameter logic [DivWidth-1:0]  InitialDivLo = 8'd1,
  parameter logic                 InitialCpol  = 1'b0,
  parameter logic                 InitialCpha  = 1'b0
) (
  input  logic                soc_clk_i,
  input  logic                rst_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [DivWidth-1:0] cfg_div_hi_i,
  input  logic [DivWidth-1:0] cfg_div_lo_i,
  input  logic                cfg_cpol_i,
  input  logic                cfg_cpha_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [CntWidth-1:0] req_len_i,
`ifdef SPI_SCLK_CTRL_ABORT_EN
  input  logic                abort_i,
`endif
  output logic                sclk_o,
  output logic                sample_o,
  output logic                shift_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [CntWidth:0] BurstOne = {{CntWidth{1'b0}}, 1'b1};
  localparam logic [CntWidth:0] BurstMax = {1'b1, {CntWidth{1'b0}}};

  state_e              state_r, state_s;
  sclk_cfg_t           cfg_r, cfg_in_s, cfg_rst_s, cfg_eff_s;
  logic [CntWidth:0]   burst_r, burst_s;
  logic                sclk_r, sclk_s;
  logic                sample_r, sample_s;
  logic                shift_r, shift_s;
  logic                done_r, done_s;
  logic                busy_r, busy_s;
  logic                cfg_acc_s, req_acc_s, abort_s;
  logic                hc_load_s, hc_expire_s;
  logic [DivWidth-1:0] hc_val_s;
  logic                unused_cfg_s;

`ifdef SPI_SCLK_CTRL_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  // Handshakes are only possible while no burst is running.
  assign cfg_acc_s   = cfg_valid_i & ~busy_r;
  assign req_acc_s   = req_valid_i & ~busy_r;
  assign cfg_ready_o = ~busy_r;
  assign req_ready_o = ~busy_r;

  // Build the incoming, reset and effective configuration records.
  always_comb begin
    cfg_in_s = {$bits(sclk_cfg_t){1'b0}};
    cfg_in_s.div_hi[DivWidth-1:0] = cfg_div_hi_i;
    cfg_in_s.div_lo[DivWidth-1:0] = cfg_div_lo_i;
    cfg_in_s.cpol = cfg_cpol_i;
    cfg_in_s.cpha = cfg_cpha_i;
    cfg_rst_s = {$bits(sclk_cfg_t){1'b0}};
    cfg_rst_s.div_hi[DivWidth-1:0] = InitialDivHi;
    cfg_rst_s.div_lo[DivWidth-1:0] = InitialDivLo;
    cfg_rst_s.cpol = InitialCpol;
    cfg_rst_s.cpha = InitialCpha;
    // A burst requested together with a config write runs on the new config.
    if (cfg_acc_s) begin
      cfg_eff_s = cfg_in_s;
    end else begin
      cfg_eff_s = cfg_r;
    end
  end

  // Upper divider bits beyond DivWidth are never used.
  assign unused_cfg_s = ^{cfg_r, cfg_eff_s};

  // Configuration register, written only while idle.
  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_r <= cfg_rst_s;
    end else if (cfg_acc_s) begin
      cfg_r <= cfg_in_s;
    end else begin
      cfg_r <= cfg_r;
    end
  end

  spi_sclk_halfcnt #(
    .DivWidth (DivWidth)
  ) u_halfcnt (
    .soc_clk_i (soc_clk_i),
    .rst_ni    (rst_ni),
    .load      (hc_load_s),
    .load_val  (hc_val_s),
    .expire    (hc_expire_s)
  );

  // Next-state and next-output logic for the half-period FSM.
  always_comb begin
    state_s   = state_r;
    burst_s   = burst_r;
    sclk_s    = sclk_r;
    sample_s  = 1'b0;
    shift_s   = 1'b0;
    done_s    = 1'b0;
    busy_s    = busy_r;
    hc_load_s = 1'b0;
    hc_val_s  = cfg_r.div_lo[DivWidth-1:0];
    case (state_r)
      IDLE: begin
        sclk_s = cfg_eff_s.cpol;
        if (req_acc_s) begin
          state_s   = LEAD;
          busy_s    = 1'b1;
          hc_load_s = 1'b1;
          hc_val_s  = cfg_eff_s.div_lo[DivWidth-1:0];
          if (req_len_i == {CntWidth{1'b0}}) begin
            burst_s = BurstMax;
          end else begin
            burst_s = {1'b0, req_len_i};
          end
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      LEAD: begin
        if (abort_s) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          sclk_s  = cfg_r.cpol;
        end else if (hc_expire_s) begin
          state_s   = ACT;
          sclk_s    = ~cfg_r.cpol;
          sample_s  = sample_on_lead(cfg_r);
          shift_s   = ~sample_on_lead(cfg_r);
          hc_load_s = 1'b1;
          hc_val_s  = cfg_r.div_hi[DivWidth-1:0];
        end else begin
          state_s = LEAD;
        end
      end
      ACT: begin
        if (abort_s) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          sclk_s  = cfg_r.cpol;
        end else if (hc_expire_s) begin
          sclk_s   = cfg_r.cpol;
          sample_s = ~sample_on_lead(cfg_r);
          shift_s  = sample_on_lead(cfg_r);
          if (burst_r == BurstOne) begin
            state_s = IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s   = LEAD;
            burst_s   = burst_r - BurstOne;
            hc_load_s = 1'b1;
            hc_val_s  = cfg_r.div_lo[DivWidth-1:0];
          end
        end else begin
          state_s = ACT;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        sclk_s  = cfg_r.cpol;
      end
    endcase
  end

  // State, burst counter and registered outputs.
  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      burst_r  <= {(CntWidth+1){1'b0}};
      sclk_r   <= InitialCpol;
      sample_r <= 1'b0;
      shift_r  <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      burst_r  <= burst_s;
      sclk_r   <= sclk_s;
      sample_r <= sample_s;
      shift_r  <= shift_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
    end
  end

  assign sclk_o   = sclk_r;
  assign sample_o = sample_r;
  assign shift_o  = shift_r;
  assign done_o   = done_r;
  assign busy_o   = busy_r;

endmodule
